// File: rtl/therm_encoder_pkg.sv
// Shared defaults for the BMU thermometer-mask encoder.
package therm_encoder_pkg;

  localparam int unsigned ThermWidthDef = 64;
  localparam int unsigned ThermChunkDef = 8;

endpackage

// File: rtl/chunk_lead_ones.sv
// Combinational leading-ones count of a CHUNK-bit slice, MSB first.
module chunk_lead_ones #(
  parameter  int unsigned CHUNK = 8,
  localparam int unsigned LW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] i_slice,
  output logic [LW-1:0]    o_count
);

  logic w_run;

  always_comb begin
    o_count = '0;
    w_run   = 1'b1;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (w_run && i_slice[i]) begin
        o_count = o_count + LW'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/therm_encoder.sv
// Iterative thermometer-mask to leading-ones count encoder, CHUNK bits per cycle from the MSB,
// with all-ones and malformed-mask flags. Valid/ready on both sides.
module therm_encoder
  import therm_encoder_pkg::*;
#(
  parameter int unsigned WIDTH = ThermWidthDef,
  parameter int unsigned CHUNK = ThermChunkDef,
  localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] Mask,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [CW-1:0]    Count,
  output logic             AllOnes,
  output logic             Malformed
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned LW     = $clog2(CHUNK + 1);
  localparam int unsigned NW     = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_acc;
  logic [NW-1:0]    r_nleft;
  logic             r_all;
  logic             r_mal;

  logic [LW-1:0]    w_lead;
  logic             w_full;
  logic             w_last;
  logic [WIDTH-1:0] w_below;
  logic             w_mal;

  chunk_lead_ones #(
    .CHUNK(CHUNK)
  ) u_chunk_lead_ones (
    .i_slice(r_sr[WIDTH-1 -: CHUNK]),
    .o_count(w_lead)
  );

  assign w_full  = (w_lead == LW'(CHUNK));
  assign w_last  = (r_nleft == NW'(1));
  // Everything strictly below the first zero; earlier chunks were all ones and are shifted out.
  assign w_below = {WIDTH{1'b1}} >> (int'(w_lead) + 1);
  assign w_mal   = |(r_sr & w_below);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (InValid) w_state_next = StScan;
      StScan:  if (!w_full || w_last) w_state_next = StDone;
      StDone:  if (OutReady) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (Flush) begin
      w_state_next = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || Flush) begin
      r_sr    <= '0;
      r_acc   <= '0;
      r_nleft <= '0;
      r_all   <= 1'b0;
      r_mal   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (InValid) begin
            r_sr    <= Mask;
            r_acc   <= '0;
            r_nleft <= NW'(NCHUNK);
            r_all   <= 1'b0;
            r_mal   <= 1'b0;
          end
        end
        StScan: begin
          r_acc <= r_acc + CW'(w_lead);
          if (w_full) begin
            if (w_last) begin
              r_all <= 1'b1;
              r_mal <= 1'b0;
            end else begin
              r_sr    <= r_sr << CHUNK;
              r_nleft <= r_nleft - NW'(1);
            end
          end else begin
            r_mal <= w_mal;
          end
        end
        default: ;
      endcase
    end
  end

  assign InReady   = (r_state == StIdle);
  assign OutValid  = (r_state == StDone);
  assign Count     = r_acc;
  assign AllOnes   = r_all;
  assign Malformed = r_mal;

endmodule

// File: tb/tb_therm_encoder.sv
// Directed plus randomized bench for therm_encoder against a bit-loop reference model.
module tb_therm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [63:0] Mask;
  logic        OutValid;
  logic        OutReady;
  logic [6:0]  Count;
  logic        AllOnes;
  logic        Malformed;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  therm_encoder #(
    .WIDTH(64),
    .CHUNK(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Flush    (Flush),
    .InValid  (InValid),
    .InReady  (InReady),
    .Mask     (Mask),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Count    (Count),
    .AllOnes  (AllOnes),
    .Malformed(Malformed)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(input logic [63:0] m);
    int c = 0;
    for (int i = 63; i >= 0; i--) begin
      if (!m[i]) break;
      c++;
    end
    return c;
  endfunction

  function automatic bit ref_mal(input logic [63:0] m);
    int c = ref_count(m);
    for (int i = 62 - c; i >= 0; i--) begin
      if (m[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int ref_k(input logic [63:0] m);
    int k = ref_count(m) / 8 + 1;
    return (k > 8) ? 8 : k;
  endfunction

  // Wait for InReady, offer m, then expect the result k+1 cycles after the accept cycle.
  task automatic run(input string tag, input logic [63:0] m, input int hold);
    int c, lat, guard;
    c = ref_count(m);
    guard = 0;
    while (!InReady && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, ".rdy"}, 64'(InReady), 64'd1);
    Mask    = m;
    InValid = 1'b1;
    lat     = 0;
    do begin
      tick();
      lat++;
      InValid = 1'b0;
      Mask    = ~m;
    end while (!OutValid && lat < 40);
    check({tag, ".lat"}, 64'(lat), 64'(ref_k(m) + 1));
    check({tag, ".cnt"}, 64'(Count), 64'(c));
    check({tag, ".all"}, 64'(AllOnes), 64'(c == 64));
    check({tag, ".mal"}, 64'(Malformed), 64'(ref_mal(m)));
    check({tag, ".busy"}, 64'(InReady), 64'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, ".hv"}, 64'(OutValid), 64'd1);
      check({tag, ".hc"}, 64'(Count), 64'(c));
      check({tag, ".hr"}, 64'(InReady), 64'd0);
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    check({tag, ".idle"}, 64'(InReady), 64'd1);
    check({tag, ".ovl"}, 64'(OutValid), 64'd0);
  endtask

  task automatic abort_scan(input string tag, input bit use_reset);
    Mask    = '1;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    tick();
    tick();
    if (use_reset) reset = 1'b1;
    else Flush = 1'b1;
    tick();
    reset = 1'b0;
    Flush = 1'b0;
    check({tag, ".ov"}, 64'(OutValid), 64'd0);
    check({tag, ".ir"}, 64'(InReady), 64'd1);
    check({tag, ".cnt"}, 64'(Count), 64'd0);
    run({tag, ".next"}, 64'hC000_0000_0000_0000, 0);
  endtask

  initial begin
    logic [63:0] m;
    int          c;
    int          guard;
    reset    = 1'b1;
    Flush    = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    Mask     = '0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst.ir", 64'(InReady), 64'd1);
    check("rst.ov", 64'(OutValid), 64'd0);
    check("rst.cnt", 64'(Count), 64'd0);
    check("rst.all", 64'(AllOnes), 64'd0);
    check("rst.mal", 64'(Malformed), 64'd0);

    run("zero", 64'h0000_0000_0000_0000, 0);
    run("c20", 64'hFFFF_F000_0000_0000, 0);
    run("ones", 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("malf", 64'hFF00_0000_0000_0001, 0);
    run("hold", 64'hE000_0000_0000_0000, 5);
    run("c63", 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run("m63", 64'hFFFF_FFFF_FFFF_FF7F, 0);

    abort_scan("rstscan", 1'b1);
    abort_scan("flscan", 1'b0);

    // Flush beats a simultaneous OutReady handshake and drops the result.
    Mask    = 64'hF000_0000_0000_0000;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    guard   = 0;
    while (!OutValid && guard < 20) begin
      tick();
      guard++;
    end
    check("fldone.ov", 64'(OutValid), 64'd1);
    Flush    = 1'b1;
    OutReady = 1'b1;
    tick();
    Flush    = 1'b0;
    OutReady = 1'b0;
    check("fldone.ir", 64'(InReady), 64'd1);
    check("fldone.cnt", 64'(Count), 64'd0);

    // InValid held through SCAN with a different Mask must not disturb the captured one.
    Mask    = 64'hFFF0_0000_0000_0000;
    InValid = 1'b1;
    tick();
    Mask  = '1;
    guard = 0;
    while (!OutValid && guard < 20) begin
      tick();
      guard++;
    end
    InValid = 1'b0;
    check("hold_iv.cnt", 64'(Count), 64'd12);
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;

    for (int t = 0; t < 40; t++) begin
      c = $urandom_range(0, 64);
      m = (c == 0) ? 64'd0 : (~64'd0 << (64 - c));
      if (c < 63 && ($urandom_range(0, 2) == 0)) begin
        m[$urandom_range(0, 62 - c)] = 1'b1;
      end
      run($sformatf("rnd%0d", t), m, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
